dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the byte-addressed data memory.
- Shares the memory between port 0 (pipeline MEM stage load/store) and port 1 (debug/loader port).
- Serialises accesses into a fixed IDLE→ISSUE→DONE sequence and drives mutually exclusive read/write enables.
- Blocks out-of-range accesses and reports them as errors.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Two requester ports plus the data-memory side of the arbiter.
// slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [2:0]  p0_func3;
  logic        p0_done;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [2:0]  p1_func3;
  logic        p1_done;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_read_ena;
  logic        mem_write_ena;
  logic [2:0]  mem_func3;
  logic [31:0] mem_out;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_func3,
    output p0_done, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_func3,
    output p1_done, p1_rdata, p1_err,
    output mem_addr, mem_data, mem_read_ena,
    output mem_write_ena, mem_func3,
    input  mem_out
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_func3,
    input  p0_done, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_func3,
    input  p1_done, p1_rdata, p1_err,
    input  mem_addr, mem_data, mem_read_ena,
    input  mem_write_ena, mem_func3,
    output mem_out
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE->ISSUE->DONE sequencer with bounds check.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: port 0 priority).
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  func3_q, func3_d;
  logic        we_q, we_d;
  logic        gnt_q, gnt_d;
  logic        rena_q, rena_d;
  logic        wena_q, wena_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;

  logic        any_req;
  logic        sel;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic [32:0] req_size;
  logic [32:0] req_end;
  logic        oob;

  assign any_req = bus.p0_req | bus.p1_req;

`ifdef DMEM_ARB_RR_EN
  // ptr_q names the port that wins the next tie.
  logic ptr_q, ptr_d;

  always_comb begin
    if (bus.p0_req && bus.p1_req) sel = ptr_q;
    else                          sel = bus.p1_req;
  end
`else
  always_comb sel = ~bus.p0_req;
`endif

  assign req_we    = sel ? bus.p1_we    : bus.p0_we;
  assign req_addr  = sel ? bus.p1_addr  : bus.p0_addr;
  assign req_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
  assign req_func3 = sel ? bus.p1_func3 : bus.p0_func3;

  always_comb begin
    unique case (req_func3[1:0])
      2'b00:   req_size = 33'd1;
      2'b01:   req_size = 33'd2;
      default: req_size = 33'd4;
    endcase
  end

  // 33-bit sum so an address near 0xFFFFFFFF cannot wrap into range.
  assign req_end = {1'b0, req_addr} + req_size;
  assign oob     = req_end > 33'(MEM_SIZE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    func3_d  = func3_q;
    we_d     = we_q;
    gnt_d    = gnt_q;
    rena_d   = 1'b0;
    wena_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
`ifdef DMEM_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = sel;
          we_d    = req_we;
          addr_d  = req_addr;
          data_d  = req_wdata;
          func3_d = req_func3;
`ifdef DMEM_ARB_RR_EN
          ptr_d   = ~sel;
`endif
          if (oob) begin
            state_d = S_DONE;
            done0_d = ~sel;
            done1_d = sel;
            err0_d  = ~sel;
            err1_d  = sel;
          end else begin
            state_d = S_ISSUE;
            rena_d  = ~req_we;
            wena_d  = req_we;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_DONE;
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        if (!we_q) begin
          if (gnt_q) rdata1_d = bus.mem_out;
          else       rdata0_d = bus.mem_out;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      func3_q  <= '0;
      we_q     <= 1'b0;
      gnt_q    <= 1'b0;
      rena_q   <= 1'b0;
      wena_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      func3_q  <= func3_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      rena_q   <= rena_d;
      wena_q   <= wena_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign bus.p0_done       = done0_q;
  assign bus.p0_rdata      = rdata0_q;
  assign bus.p0_err        = err0_q;
  assign bus.p1_done       = done1_q;
  assign bus.p1_rdata      = rdata1_q;
  assign bus.p1_err        = err1_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_data      = data_q;
  assign bus.mem_func3     = func3_q;
  assign bus.mem_read_ena  = rena_q;
  assign bus.mem_write_ena = wena_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model.
// Tie expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  logic wipe;
  int   n_cmp;
  int   n_err;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_SIZE(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (bus.mem_write_ena) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_data[7:0];
      if (bus.mem_func3[1:0] != 2'b00)
        mem[10'(bus.mem_addr[9:0] + 10'd1)] <= bus.mem_data[15:8];
      if (bus.mem_func3[1] == 1'b1) begin
        mem[10'(bus.mem_addr[9:0] + 10'd2)] <= bus.mem_data[23:16];
        mem[10'(bus.mem_addr[9:0] + 10'd3)] <= bus.mem_data[31:24];
      end
    end
  end

  function automatic logic [31:0] ld(input logic [31:0] a,
                                     input logic [2:0] f);
    logic [9:0]  i;
    logic [31:0] w;
    i = a[9:0];
    w = {mem[10'(i + 10'd3)], mem[10'(i + 10'd2)],
         mem[10'(i + 10'd1)], mem[i]};
    case (f[1:0])
      2'b00:   return f[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2'b01:   return f[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(negedge clk)
    if (bus.mem_read_ena)
      bus.mem_out <= ld(bus.mem_addr, bus.mem_func3);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p0_set(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
    bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = a;
    bus.p0_wdata = d; bus.p0_func3 = f;
  endtask

  task automatic p1_set(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
    bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a;
    bus.p1_wdata = d; bus.p1_func3 = f;
  endtask

  initial begin
    logic exp0;
    n_cmp = 0;
    n_err = 0;
    wipe  = 1'b1;
    reset = 1'b1;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0;
    bus.p0_wdata = '0; bus.p0_func3 = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0;
    bus.p1_wdata = '0; bus.p1_func3 = '0;
    tick();
    tick();
    chk("rst_done0", 32'(bus.p0_done), 0);
    chk("rst_done1", 32'(bus.p1_done), 0);
    chk("rst_ena", 32'({bus.mem_read_ena, bus.mem_write_ena}), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rdata", bus.p0_rdata | bus.p1_rdata, 0);
    reset = 1'b0;
    wipe  = 1'b0;
    tick();

    // p0 word write, then readback
    p0_set(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    tick();
    chk("wr_wena", 32'({bus.mem_read_ena, bus.mem_write_ena}), 1);
    chk("wr_addr", bus.mem_addr, 32'h10);
    chk("wr_data", bus.mem_data, 32'hDEADBEEF);
    chk("wr_early", 32'(bus.p0_done), 0);
    bus.p0_req = 1'b0;
    tick();
    chk("wr_done", 32'({bus.p0_done, bus.p0_err}), 32'b10);
    chk("wr_rdata", bus.p0_rdata, 0);
    chk("wr_ena_off", 32'({bus.mem_read_ena, bus.mem_write_ena}), 0);
    tick();
    chk("wr_idle", 32'(bus.p0_done), 0);

    p0_set(1'b0, 32'h10, 32'h0, 3'b010);
    tick();
    chk("rd_rena", 32'({bus.mem_read_ena, bus.mem_write_ena}), 32'b10);
    bus.p0_req = 1'b0;
    tick();
    chk("rd_done", 32'({bus.p0_done, bus.p0_err}), 32'b10);
    chk("rd_rdata", bus.p0_rdata, 32'hDEADBEEF);
    tick();

    // p1 LB / LBU
    p1_set(1'b0, 32'h10, 32'h0, 3'b000);
    tick();
    bus.p1_req = 1'b0;
    tick();
    chk("lb_done", 32'({bus.p1_done, bus.p1_err}), 32'b10);
    chk("lb_rdata", bus.p1_rdata, 32'hFFFFFFEF);
    chk("lb_p0", 32'({bus.p0_done, bus.p0_err}), 0);
    chk("lb_p0rd", bus.p0_rdata, 0);
    tick();
    p1_set(1'b0, 32'h10, 32'h0, 3'b100);
    tick();
    bus.p1_req = 1'b0;
    tick();
    chk("lbu_rdata", bus.p1_rdata, 32'h000000EF);
    chk("lbu_p0", 32'(bus.p0_done), 0);
    tick();

    // simultaneous requests, four transactions
    p0_set(1'b0, 32'h10, 32'h0, 3'b010);
    p1_set(1'b0, 32'h10, 32'h0, 3'b000);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      tick();
      tick();
      chk($sformatf("tie%0d", i), 32'({bus.p0_done, bus.p1_done}),
          32'({exp0, ~exp0}));
      tick();
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    tick();

    // bounds: word at 0x3FE errors with one-cycle latency
    p1_set(1'b0, 32'h3FE, 32'h0, 3'b010);
    tick();
    chk("oob_done", 32'({bus.p1_done, bus.p1_err}), 32'b11);
    chk("oob_rdata", bus.p1_rdata, 0);
    chk("oob_ena", 32'({bus.mem_read_ena, bus.mem_write_ena}), 0);
    bus.p1_req = 1'b0;
    tick();
    chk("oob_ena2", 32'({bus.mem_read_ena, bus.mem_write_ena}), 0);
    chk("oob_clear", 32'(bus.p1_done), 0);
    tick();
    p1_set(1'b0, 32'h3FF, 32'h0, 3'b100);
    tick();
    chk("edge_rena", 32'(bus.mem_read_ena), 1);
    bus.p1_req = 1'b0;
    tick();
    chk("edge_done", 32'({bus.p1_done, bus.p1_err}), 32'b10);
    tick();

    // wrap at top of address space
    p0_set(1'b1, 32'hFFFFFFFF, 32'h1234, 3'b001);
    tick();
    chk("wrap_done", 32'({bus.p0_done, bus.p0_err}), 32'b11);
    chk("wrap_wena", 32'(bus.mem_write_ena), 0);
    bus.p0_req = 1'b0;
    tick();
    chk("wrap_wena2", 32'(bus.mem_write_ena), 0);
    tick();

    // reset during ISSUE of a p0 read
    p0_set(1'b0, 32'h10, 32'h0, 3'b010);
    tick();
    chk("mid_rena", 32'(bus.mem_read_ena), 1);
    reset = 1'b1;
    bus.p0_req = 1'b0;
    tick();
    chk("mid_done", 32'(bus.p0_done), 0);
    chk("mid_ena", 32'({bus.mem_read_ena, bus.mem_write_ena}), 0);
    chk("mid_rdata", bus.p0_rdata, 0);
    chk("mid_addr", bus.mem_addr, 0);
    reset = 1'b0;
    tick();
    chk("mid_nodone", 32'(bus.p0_done), 0);
    p0_set(1'b0, 32'h10, 32'h0, 3'b010);
    tick();
    chk("post_rena", 32'(bus.mem_read_ena), 1);
    bus.p0_req = 1'b0;
    tick();
    chk("post_done", 32'({bus.p0_done, bus.p0_err}), 32'b10);
    chk("post_rdata", bus.p0_rdata, 32'hDEADBEEF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
